// File: rtl/ps2_pkg.sv
// Shared register map, bit positions and receiver state encoding for the PS/2 FIFO peripheral.
package ps2_pkg;

  localparam logic [31:0] REG_CTRL   = 32'd0;
  localparam logic [31:0] REG_STATUS = 32'd1;
  localparam logic [31:0] REG_DATA   = 32'd2;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_FLUSH  = 2;

  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_PERR    = 3;
  localparam int unsigned ST_FERR    = 4;
  localparam int unsigned ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronisers, PS2C glitch filter, frame FSM and mid-frame timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic [7:0] code_o,
  output logic       valid_o,
  output logic       perr_o,
  output logic       ferr_o
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] csync_q, dsync_q;
  logic                   c_s, d_s;
  logic                   filt_q, filt_d, fall;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  rx_state_e              state_q, state_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;

  assign c_s = csync_q[SYNC_STAGES-1];
  assign d_s = dsync_q[SYNC_STAGES-1];

  // The filtered clock only follows PS2C after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (c_s != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = c_s;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tmo_d    = tmo_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      tmo_d   = '0;
    end else if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      tmo_d   = '0;
      ferr_d  = 1'b1;
    end else begin
      tmo_d = (fall || state_q == IDLE) ? '0 : tmo_q + TW'(1);
      case (state_q)
        IDLE: if (fall && !d_s) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
        DATA: if (fall) begin
          shift_d  = {d_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: if (fall) begin
          par_d   = d_s;
          state_d = STOP;
        end
        STOP: if (fall) begin
          state_d = IDLE;
          if (!d_s)                      ferr_d  = 1'b1;
          else if (!(^{shift_q, par_q})) perr_d  = 1'b1;
          else                           valid_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csync_q  <= '1;
      dsync_q  <= '1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      csync_q  <= {csync_q[SYNC_STAGES-2:0], ps2c_i};
      dsync_q  <= {dsync_q[SYNC_STAGES-2:0], ps2d_i};
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  // shift_q is frozen in IDLE, so it still holds the code during the valid pulse.
  assign code_o  = shift_q;
  assign valid_o = valid_q;
  assign perr_o  = perr_q;
  assign ferr_o  = ferr_q;

endmodule

// File: rtl/ps2_rx_fifo_periph.sv
// Memory-mapped PS/2 receiver with scancode FIFO, sticky error status and level interrupt.
module ps2_rx_fifo_periph
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_WEnable,
  input  logic [31:0] i_WAddr,
  input  logic [31:0] i_WData,
  input  logic        i_REnable,
  input  logic [31:0] i_RAddr,
  output logic [31:0] o_RData,
  output logic        o_Err,
  output logic        o_Irq,
  input  logic        PS2C,
  input  logic        PS2D
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic        en_q, en_d, irqen_q, irqen_d;
  logic        ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  rx_code;
  logic        rx_valid, rx_perr, rx_ferr;
  logic        wr, rd, empty, full, flush, pop, do_push, ovf_set;
  logic [2:0]  clr;
  logic [15:0] cnt16;
  logic [31:0] status_w;
  logic        unused_wdata;

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk_i   (i_Clk),
    .rst_i   (i_Rst),
    .enable_i(en_q),
    .ps2c_i  (PS2C),
    .ps2d_i  (PS2D),
    .code_o  (rx_code),
    .valid_o (rx_valid),
    .perr_o  (rx_perr),
    .ferr_o  (rx_ferr)
  );

  assign unused_wdata = ^i_WData[31:5];
  assign wr    = i_WEnable;
  assign rd    = i_REnable & ~i_WEnable;
  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign cnt16 = 16'(count_q);

  always_comb begin
    status_w                            = '0;
    status_w[ST_EMPTY]                  = empty;
    status_w[ST_FULL]                   = full;
    status_w[ST_OVF]                    = ovf_q;
    status_w[ST_PERR]                   = perr_q;
    status_w[ST_FERR]                   = ferr_q;
    status_w[ST_CNT_LSB+7:ST_CNT_LSB]   = cnt16[7:0];
    en_d    = en_q;
    irqen_d = irqen_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    clr     = '0;
    flush   = 1'b0;
    pop     = 1'b0;
    if (wr) begin
      case (i_WAddr)
        REG_CTRL: begin
          en_d    = i_WData[CTRL_EN];
          irqen_d = i_WData[CTRL_IRQ_EN];
          flush   = i_WData[CTRL_FLUSH];
          err_d   = 1'b0;
        end
        REG_STATUS: begin
          clr   = i_WData[ST_FERR:ST_OVF];
          err_d = 1'b0;
        end
        default: err_d = 1'b1;
      endcase
    end else if (rd) begin
      case (i_RAddr)
        REG_CTRL: begin
          rdata_d = {30'b0, irqen_q, en_q};
          err_d   = 1'b0;
        end
        REG_STATUS: begin
          rdata_d = status_w;
          err_d   = 1'b0;
        end
        REG_DATA: begin
          rdata_d = empty ? '0 : {23'b0, 1'b1, mem_q[rptr_q]};
          pop     = ~empty;
          err_d   = 1'b0;
        end
        default: err_d = 1'b1;
      endcase
    end

    // A pop frees the slot the same cycle, so a push into a full FIFO still lands.
    do_push = rx_valid & ~flush & (~full | pop);
    ovf_set = rx_valid & ~flush & full & ~pop;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + AW'(do_push);
      rptr_d  = rptr_q + AW'(pop);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(pop);
    end
    ovf_d  = (ovf_q  & ~clr[0]) | ovf_set;
    perr_d = (perr_q & ~clr[1]) | rx_perr;
    ferr_d = (ferr_q & ~clr[2]) | rx_ferr;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      en_q    <= 1'b0;
      irqen_q <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      en_q    <= en_d;
      irqen_q <= irqen_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (do_push) mem_q[wptr_q] <= rx_code;
  end

  assign o_RData = rdata_q;
  assign o_Err   = err_q;
  assign o_Irq   = irqen_q & ~empty;

endmodule

// File: tb/tb_ps2_rx_fifo_periph.sv
// Scenario bench for ps2_rx_fifo_periph with a scoreboard of expected DATA-register reads.
module tb_ps2_rx_fifo_periph;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FLT   = 8;
  localparam int unsigned TMO   = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen, ren;
  logic [31:0] waddr, wdata, raddr;
  logic [31:0] rdata;
  logic        err, irq;
  logic        ps2c, ps2d;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  ps2_rx_fifo_periph #(
    .FIFO_DEPTH    (DEPTH),
    .SYNC_STAGES   (2),
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_WEnable(wen),
    .i_WAddr  (waddr),
    .i_WData  (wdata),
    .i_REnable(ren),
    .i_RAddr  (raddr),
    .o_RData  (rdata),
    .o_Err    (err),
    .o_Irq    (irq),
    .PS2C     (ps2c),
    .PS2D     (ps2d)
  );

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wen = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    @(negedge clk);
    ren = 1'b1; raddr = a;
    @(negedge clk);
    ren = 1'b0;
    d = rdata; e = err;
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;  tick(10);
    ps2c = 1'b0; tick(20);
    ps2c = 1'b1; tick(10);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par, input logic stop);
    send_bit(1'b0);
    for (int unsigned i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(par);
    send_bit(stop);
    ps2d = 1'b1;
    tick(10);
  endtask

  task automatic send_good(input logic [7:0] code);
    send_frame(code, ~^code, 1'b1);
    if (sb_q.size() < DEPTH) sb_q.push_back({23'b0, 1'b1, code});
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    bus_read(32'd1, d, e);
    n_total++;
    if (d !== exp || e !== 1'b0) $display("FAIL %s: STATUS got %h err %b, want %h err 0", name, d, e, exp);
    else n_pass++;
  endtask

  task automatic check_data_read(input string name);
    logic [31:0] d, exp;
    logic e;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'h0;
    bus_read(32'd2, d, e);
    n_total++;
    if (d !== exp || e !== 1'b0) $display("FAIL %s: DATA got %h err %b, want %h err 0", name, d, e, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    n_total++;
    if (rdata !== 32'h0 || err !== 1'b0 || irq !== 1'b0)
      $display("FAIL reset_outputs: rdata %h err %b irq %b, want 0 0 0", rdata, err, irq);
    else n_pass++;
    check_status("reset_status", 32'h0000_0001);
    bus_read(32'd0, d, e);
    n_total++;
    if (d !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", d);
    else n_pass++;
  endtask

  task automatic test_valid_frame();
    bus_write(32'd0, 32'h1);
    send_good(8'h1C);
    check_status("valid_count1", 32'h0000_0100);
    check_data_read("valid_data");
    check_status("valid_empty", 32'h0000_0001);
  endtask

  task automatic test_parity_err();
    send_frame(8'h1C, 1'b1, 1'b1);
    check_status("parity_set", 32'h0000_0009);
    bus_write(32'd1, 32'h08);
    check_status("parity_clr", 32'h0000_0001);
  endtask

  task automatic test_overflow();
    for (int unsigned i = 1; i <= 5; i++) send_good(8'(i));
    check_status("ovf_full", 32'h0000_0406);
    for (int unsigned i = 0; i < 5; i++) check_data_read("ovf_drain");
    bus_write(32'd1, 32'h04);
    check_status("ovf_clr", 32'h0000_0001);
  endtask

  task automatic test_timeout();
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    ps2d = 1'b1;
    tick(TMO + 60);
    check_status("timeout_ferr", 32'h0000_0011);
    send_good(8'h5A);
    check_data_read("timeout_next");
    bus_write(32'd1, 32'h10);
    check_status("timeout_clr", 32'h0000_0001);
  endtask

  task automatic test_stop_err();
    send_frame(8'h1C, 1'b0, 1'b0);
    check_status("stop_ferr", 32'h0000_0011);
    bus_write(32'd1, 32'h10);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    ps2d = 1'b0; ps2c = 1'b0;
    tick(FLT - 1);
    ps2c = 1'b1; ps2d = 1'b1;
    tick(20);
    send_good(8'h33);
    check_status("glitch_status", 32'h0000_0100);
    check_data_read("glitch_data");
  endtask

  task automatic test_irq_flush();
    logic [31:0] d;
    logic e;
    bus_write(32'd0, 32'h3);
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_idle: got %b want 0", irq);
    else n_pass++;
    send_good(8'h22);
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_rise: got %b want 1", irq);
    else n_pass++;
    bus_write(32'd0, 32'h7);
    sb_q.delete();
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_flush: got %b want 0", irq);
    else n_pass++;
    check_status("flush_status", 32'h0000_0001);
    bus_read(32'd0, d, e);
    n_total++;
    if (d !== 32'h3) $display("FAIL ctrl_flush_rd: got %h want 3", d);
    else n_pass++;
  endtask

  task automatic test_access_err();
    logic [31:0] d;
    logic e;
    bus_read(32'd0, d, e);
    bus_read(32'd5, d, e);
    n_total++;
    if (e !== 1'b1 || d !== 32'h3) $display("FAIL bad_read: err %b rdata %h, want 1 3", e, d);
    else n_pass++;
    bus_read(32'd0, d, e);
    n_total++;
    if (e !== 1'b0) $display("FAIL good_read: err %b want 0", e);
    else n_pass++;
    bus_write(32'd2, 32'h0);
    n_total++;
    if (err !== 1'b1) $display("FAIL data_write: err %b want 1", err);
    else n_pass++;
    @(negedge clk);
    wen = 1'b1; waddr = 32'd1; wdata = 32'h0; ren = 1'b1; raddr = 32'd5;
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    n_total++;
    if (err !== 1'b0 || rdata !== 32'h3) $display("FAIL wr_wins: err %b rdata %h, want 0 3", err, rdata);
    else n_pass++;
  endtask

  task automatic test_enable_abort();
    bus_write(32'd0, 32'h1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_write(32'd0, 32'h0);
    bus_write(32'd0, 32'h1);
    tick(TMO + 60);
    check_status("abort_noerr", 32'h0000_0001);
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; ren = 1'b0;
    waddr = '0; wdata = '0; raddr = '0;
    ps2c = 1'b1; ps2d = 1'b1;
    tick(5);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_valid_frame();
    test_parity_err();
    test_overflow();
    test_timeout();
    test_stop_err();
    test_glitch();
    test_irq_flush();
    test_access_err();
    test_enable_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
